// File: rtl/operand_fetch.sv
// operand_fetch: decode-and-operand-fetch stage placed in front of RegisterFile.
// An instruction accepted over the input handshake is held in the instruction
// register (IR). The IR drives the register-file read addresses. One cycle
// later the operands and decoded fields are captured and presented downstream.
// Writes on the register-file write port are snooped. A write in the capture
// cycle is forwarded, so an operand never holds the pre-write value.
// Build option: define OPERAND_REFRESH_EN to keep the captured operands
// tracking snooped writes while the stage waits in VALID.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [ADDR_W-1:0] read_address_0,
    output logic [ADDR_W-1:0] read_address_1,
    input  logic [DATA_W-1:0] read_data_0,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_address_0,
    input  logic [DATA_W-1:0] write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] imm_ext,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] dest_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;

    logic [31:0]        ir;
    logic               loadIr;
    logic               capture;
    logic               inReady;
    logic               outValid;

    logic [ADDR_W-1:0]  rsAddr;
    logic [ADDR_W-1:0]  rtAddr;
    logic [ADDR_W-1:0]  rdAddr;

    logic [DATA_W-1:0]  opA;
    logic [DATA_W-1:0]  opB;
    logic [DATA_W-1:0]  immExtQ;
    logic [5:0]         opcodeQ;
    logic [5:0]         functQ;
    logic [ADDR_W-1:0]  destQ;

    // Register fields of the held instruction; these feed the register file
    // in every state, not only during READ.
    assign rsAddr = ir[25:21];
    assign rtAddr = ir[20:16];
    assign rdAddr = ir[15:11];

    // Operand selection for one read port. Register 0 is hard-wired to zero.
    // A same-cycle write to the addressed register takes priority over the
    // register-file output, because that output still shows the old value.
    function automatic logic [DATA_W-1:0] fetchOperand(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rdata,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (we && (wa == addr)) begin
            value = wd;
        end else begin
            value = rdata;
        end
        return value;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments. Every flop then
        // sees pre-edge values, whatever order the blocks evaluate in.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and handshake signals
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a signal unassigned would otherwise infer a latch.
        nextState = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        loadIr    = 1'b0;
        capture   = 1'b0;

        unique case (state)
            IDLE: begin
                inReady = 1'b1;
                if (in_valid) begin
                    loadIr    = 1'b1;
                    nextState = READ;
                end
            end
            READ: begin
                capture   = 1'b1;
                nextState = VALID;
            end
            VALID: begin
                outValid = 1'b1;
                inReady  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        loadIr    = 1'b1;
                        nextState = READ;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // While reset is held, neither handshake may complete.
        if (!rst_n) begin
            inReady  = 1'b0;
            outValid = 1'b0;
            loadIr   = 1'b0;
            capture  = 1'b0;
        end
    end

    // Instruction register: loads on every accepted input handshake.
    always_ff @(posedge clk) begin
        // NOTE: the IR is reset, not left free-running. The read addresses
        // come straight from it and must read as zero out of reset.
        if (!rst_n) begin
            ir <= '0;
        end else if (loadIr) begin
            ir <= in_instr;
        end
    end

`ifdef OPERAND_REFRESH_EN
    logic refreshA;
    logic refreshB;

    // While waiting in VALID, a write to a nonzero source register replaces
    // the captured operand. A stalled consumer therefore sees the newest value.
    assign refreshA = (state == VALID) && write_en && (rsAddr != '0)
                      && (write_address_0 == rsAddr);
    assign refreshB = (state == VALID) && write_en && (rtAddr != '0)
                      && (write_address_0 == rtAddr);
`endif

    // Operand registers A and B: captured at the end of READ with forwarding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opA <= '0;
            opB <= '0;
        end else if (capture) begin
            opA <= fetchOperand(rsAddr, read_data_0, write_en, write_address_0, write_data);
            opB <= fetchOperand(rtAddr, read_data_1, write_en, write_address_0, write_data);
        end else begin
`ifdef OPERAND_REFRESH_EN
            if (refreshA) begin
                opA <= write_data;
            end
            if (refreshB) begin
                opB <= write_data;
            end
`else
            opA <= opA;
            opB <= opB;
`endif
        end
    end

    // Decoded fields: captured together with the operands and held until the
    // next capture, so they stay stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            immExtQ <= '0;
            opcodeQ <= '0;
            functQ  <= '0;
            destQ   <= '0;
        end else if (capture) begin
            immExtQ <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
            opcodeQ <= ir[31:26];
            functQ  <= ir[5:0];
            // R-type instructions write rd; all other formats write rt.
            destQ   <= (ir[31:26] == 6'd0) ? rdAddr : rtAddr;
        end
    end

    assign in_ready       = inReady;
    assign out_valid      = outValid;
    assign read_address_0 = rsAddr;
    assign read_address_1 = rtAddr;
    assign op_a           = opA;
    assign op_b           = opB;
    assign imm_ext        = immExtQ;
    assign opcode         = opcodeQ;
    assign funct          = functQ;
    assign dest_addr      = destQ;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch. A behavioural model
// follows the instructions the stage accepts and queues the expected outputs.
// A monitor compares each queued entry when the output handshake completes.
// Compile with OPERAND_REFRESH_EN defined to check the refresh build.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  read_address_0;
    logic [4:0]  read_address_1;
    logic [31:0] read_data_0;
    logic [31:0] read_data_1;
    logic        write_en;
    logic [4:0]  write_address_0;
    logic [31:0] write_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm_ext;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dest_addr;

    logic        poison;
    logic [31:0] rf [32];
    logic [31:0] modelRegs [32];

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] imm;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } exp_t;

    exp_t expQ[$];
    int   total  = 0;
    int   bad    = 0;
    int   pushed = 0;
    int   popped = 0;

    operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .read_address_0  (read_address_0),
        .read_address_1  (read_address_1),
        .read_data_0     (read_data_0),
        .read_data_1     (read_data_1),
        .write_en        (write_en),
        .write_address_0 (write_address_0),
        .write_data      (write_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .imm_ext         (imm_ext),
        .opcode          (opcode),
        .funct           (funct),
        .dest_addr       (dest_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] initVal(input int i);
        if (i == 10) return 32'd420;
        if (i == 11) return 32'd670;
        if (i == 17) return 32'd555;
        return (32'(i) * 32'h01010101) + 32'd7;
    endfunction

    // Register file seen by the stage: combinational read, write at the edge.
    // With poison set, the read ports return garbage.
    initial begin : regfile
        for (int i = 0; i < 32; i++) rf[i] = initVal(i);
        forever begin
            @(posedge clk);
            if (write_en) rf[write_address_0] <= write_data;
        end
    end
    assign read_data_0 = poison ? 32'hDEADBEEF : rf[read_address_0];
    assign read_data_1 = poison ? 32'hDEADBEEF : rf[read_address_1];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Architectural value of register r after a write that happens in the
    // same cycle.
    function automatic logic [31:0] newest(input logic [4:0] r, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wa == r) return wd;
        return modelRegs[r];
    endfunction

    function automatic exp_t predict(input logic [31:0] instr, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.rs   = instr[25:21];
        e.rt   = instr[20:16];
        e.opA  = newest(instr[25:21], we, wa, wd);
        e.opB  = newest(instr[20:16], we, wa, wd);
        e.imm  = 32'($signed(instr[15:0]));
        e.opc  = instr[31:26];
        e.fn   = instr[5:0];
        e.dest = (instr[31:26] == 6'd0) ? instr[15:11] : instr[20:16];
        return e;
    endfunction

    // Reference model. An accepted instruction has its operands fixed one
    // cycle later, using the newest register values. Writes are sampled
    // mid-cycle and applied at the following edge.
    initial begin : model
        logic        sAcc, sRst, sWe, readPending;
        logic [31:0] sInstr, pendInstr, sWd;
        logic [4:0]  sWa;
        for (int i = 0; i < 32; i++) modelRegs[i] = initVal(i);
        readPending = 1'b0;
        pendInstr   = '0;
        forever begin
            @(negedge clk);
            sRst   = rst_n;
            sAcc   = in_valid && in_ready;
            sInstr = in_instr;
            sWe    = write_en;
            sWa    = write_address_0;
            sWd    = write_data;
            @(posedge clk);
            if (!sRst) begin
                readPending = 1'b0;
                expQ.delete();
            end else begin
                if (readPending) begin
                    expQ.push_back(predict(pendInstr, sWe, sWa, sWd));
                    pushed++;
                    readPending = 1'b0;
                end
`ifdef OPERAND_REFRESH_EN
                if (sWe && sWa != 5'd0) begin
                    foreach (expQ[k]) begin
                        if (expQ[k].rs == sWa) expQ[k].opA = sWd;
                        if (expQ[k].rt == sWa) expQ[k].opB = sWd;
                    end
                end
`endif
                if (sAcc) begin
                    readPending = 1'b1;
                    pendInstr   = sInstr;
                end
            end
            if (sWe) modelRegs[sWa] = sWd;
        end
    end

    // Monitor: compares each output handshake against the queue. It also
    // checks that a stalled output stays valid and stable.
    initial begin : monitor
        logic        prevHeld;
        logic [31:0] pOpA, pOpB, pImm;
        logic [5:0]  pOpc, pFn;
        logic [4:0]  pDest;
        exp_t        e;
        prevHeld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prevHeld) begin
                    check("valid_held", out_valid, 1'b1);
                    check("imm_stable", imm_ext, pImm);
                    check("dest_stable", dest_addr, pDest);
                    check("opcode_stable", opcode, pOpc);
                    check("funct_stable", funct, pFn);
`ifndef OPERAND_REFRESH_EN
                    check("op_a_frozen", op_a, pOpA);
                    check("op_b_frozen", op_b, pOpB);
`endif
                end
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        check("expected_pending", 32'(expQ.size()), 32'd1);
                    end else begin
                        e = expQ.pop_front();
                        popped++;
                        check("op_a", op_a, e.opA);
                        check("op_b", op_b, e.opB);
                        check("imm_ext", imm_ext, e.imm);
                        check("opcode", opcode, e.opc);
                        check("funct", funct, e.fn);
                        check("dest_addr", dest_addr, e.dest);
                    end
                end
                prevHeld = out_valid && !out_ready;
                pOpA = op_a; pOpB = op_b; pImm = imm_ext;
                pOpc = opcode; pFn = funct; pDest = dest_addr;
            end else begin
                prevHeld = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present an instruction and hold it until accepted. Returns just after
    // the accepting edge, which is the READ cycle.
    task automatic sendInstr(input logic [31:0] instr);
        logic acc;
        acc = 1'b0;
        in_instr = instr;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_in_time", acc, 1'b1);
    endtask

    task automatic waitValid();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("valid_in_time", seen, 1'b1);
    endtask

    // Complete the output handshake from a negedge where out_valid is high.
    task automatic consume();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) r[25:21] = 5'd0;
        if ($urandom_range(0, 3) == 0) r[20:16] = 5'd0;
        if ($urandom_range(0, 1) == 0) r[31:26] = 6'd0;
        return r;
    endfunction

    initial begin : stimulus
        logic        acc;
        int          nAcc, nPulse, sent;
        int          pulseCyc [2];
        logic [31:0] heldOpA;

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        write_en = 1'b0; write_address_0 = '0; write_data = '0; poison = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_imm", imm_ext, 32'd0);
        check("rst_opcode", opcode, 6'd0);
        check("rst_funct", funct, 6'd0);
        check("rst_dest", dest_addr, 5'd0);
        check("rst_ra0", read_address_0, 5'd0);
        check("rst_ra1", read_address_1, 5'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // R-type add $9,$10,$11 and its latency
        @(posedge clk); #1;
        sendInstr(32'h014B4820);
        @(negedge clk);
        check("read_out_valid", out_valid, 1'b0);
        check("read_in_ready", in_ready, 1'b0);
        check("read_ra0", read_address_0, 5'd10);
        check("read_ra1", read_address_1, 5'd11);
        @(negedge clk);
        check("lat_out_valid", out_valid, 1'b1);
        check("add_op_a", op_a, 32'd420);
        check("add_op_b", op_b, 32'd670);
        check("add_dest", dest_addr, 5'd9);
        check("add_opcode", opcode, 6'd0);
        check("add_funct", funct, 6'h20);
        consume();

        // I-type addi $8,$17,-4
        sendInstr(32'h2228FFFC);
        waitValid();
        check("addi_imm", imm_ext, 32'hFFFFFFFC);
        check("addi_dest", dest_addr, 5'd8);
        check("addi_op_a", op_a, 32'd555);
        consume();

        // Same-cycle hazard on $17 during READ
        sendInstr(32'h2228FFFC);
        write_en = 1'b1; write_address_0 = 5'd17; write_data = 32'd1234;
        @(posedge clk); #1;
        write_en = 1'b0;
        @(negedge clk);
        check("hazard_valid", out_valid, 1'b1);
        check("hazard_op_a", op_a, 32'd1234);
        consume();

        // Register $0 with a poisoned register file and writes to address 0
        poison = 1'b1;
        sendInstr(32'h00001820);
        write_en = 1'b1; write_address_0 = 5'd0; write_data = 32'h77;
        @(posedge clk); #1;
        write_data = 32'h5555;
        @(posedge clk); #1;
        write_en = 1'b0;
        @(negedge clk);
        check("zero_valid", out_valid, 1'b1);
        check("zero_op_a", op_a, 32'd0);
        check("zero_op_b", op_b, 32'd0);
        consume();
        poison = 1'b0;

        // Stall for 5 cycles in VALID; write 99 to rs on the third cycle
        sendInstr(32'h2228FFFC);
        waitValid();
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            write_en = (s == 2);
            write_address_0 = 5'd17;
            write_data = 32'd99;
            @(negedge clk);
        end
        heldOpA = op_a;
`ifdef OPERAND_REFRESH_EN
        check("stall_op_a_refreshed", heldOpA, 32'd99);
`else
        check("stall_op_a_frozen", heldOpA, 32'd1234);
`endif
        consume();

        // Back-to-back with in_valid held and out_ready high
        in_instr = 32'h014B4820; in_valid = 1'b1; out_ready = 1'b1;
        nAcc = 0; nPulse = 0; pulseCyc[0] = 0; pulseCyc[1] = 0;
        for (int c = 0; c < 20 && nPulse < 2; c++) begin
            @(negedge clk);
            if (out_valid) begin
                pulseCyc[nPulse] = c;
                if (nPulse == 0) check("b2b_accept_on_handshake", in_ready, 1'b1);
                nPulse++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                nAcc++;
                if (nAcc == 1) in_instr = 32'h2228FFFC;
                else in_valid = 1'b0;
            end
        end
        check("b2b_pulses", 32'(nPulse), 32'd2);
        check("b2b_spacing", 32'(pulseCyc[1] - pulseCyc[0]), 32'd2);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset asserted during READ
        sendInstr(32'h014B4820);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_out_valid", out_valid, 1'b0);
        check("after_rst_idle", in_ready, 1'b1);
        check("after_rst_ra0", read_address_0, 5'd0);
        check("after_rst_op_a", op_a, 32'd0);

        // Randomized traffic: gaps, stalls and snooped writes
        @(posedge clk); #1;
        sent = 0;
        for (int c = 0; c < 4000 && sent < 60; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < 60 && $urandom_range(0, 1) == 1) begin
                in_instr = randInstr();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            write_en  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: write_address_0 = read_address_0;
                1: write_address_0 = read_address_1;
                default: write_address_0 = 5'($urandom);
            endcase
            write_data = $urandom;
        end
        in_valid = 1'b0; write_en = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("random_sent", 32'(sent), 32'd60);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        check("outputs_match_accepts", 32'(popped), 32'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
